// File: rtl/mips_multicycle_control_if.sv
// rtl/mips_multicycle_control_if.sv - shared instruction/data memory port between control FSM and memory
interface mips_multicycle_control_if;
    logic IorD;
    logic MemRead;
    logic MemWrite;
    logic MemReady;

    modport master (
        output IorD,
        output MemRead,
        output MemWrite,
        input  MemReady
    );

    modport slave (
        input  IorD,
        input  MemRead,
        input  MemWrite,
        output MemReady
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multi-cycle MIPS control FSM with memory handshake and retire counter
module mips_multicycle_control #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    mips_multicycle_control_if.master mem,
    input  logic [5:0]              OP,
    input  logic                    Zero,
    output logic                    IRWrite,
    output logic                    PCWrite,
    output logic [1:0]              PCSource,
    output logic                    ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [2:0]              ALUOp,
    output logic                    RegWrite,
    output logic [1:0]              RegDst,
    output logic [1:0]              MemtoReg,
    output logic                    IllegalOp,
    output logic                    MemError,
    output logic [CNT_WIDTH-1:0]    InstRetired
);

    localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_WB_ALU,
        S_MEM_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_hold;
    logic              retire;
    logic              rd_sel;
    logic              mem_state;
    logic              timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            InstRetired <= '0;
            rd_sel      <= 1'b0;
        end else begin
            state <= state_next;
            if (retire) begin
                InstRetired <= InstRetired + CNT_WIDTH'(1);
            end
            // Counter only runs while a memory state keeps waiting; any
            // handshake, timeout or state change brings it back to zero.
            if (wait_hold) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            // WB_ALU is shared by R and I formats; remember which one led here.
            if (state == S_EXEC_R) begin
                rd_sel <= 1'b1;
            end else if (state == S_EXEC_I) begin
                rd_sel <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next   = state;
        wait_hold    = 1'b0;
        retire       = 1'b0;
        mem.IorD     = 1'b0;
        mem.MemRead  = 1'b0;
        mem.MemWrite = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        PCSource     = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOp        = 3'b000;
        RegWrite     = 1'b0;
        RegDst       = 2'b00;
        MemtoReg     = 2'b00;
        IllegalOp    = 1'b0;
        MemError     = 1'b0;

        mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
        timeout   = mem_state && !mem.MemReady && (wait_cnt == WAIT_W'(MEM_WAIT_MAX));

        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
            end

            S_FETCH: begin
                mem.MemRead = 1'b1;
                ALUSrcB     = 2'b01;
                if (mem.MemReady) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout) begin
                    MemError   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    wait_hold = 1'b1;
                end
            end

            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (OP)
                    OP_RTYPE:                         state_next = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_next = S_EXEC_I;
                    OP_LW, OP_SW:                     state_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                   state_next = S_BRANCH;
                    OP_J, OP_JAL:                     state_next = S_JUMP;
                    default: begin
                        // PC already advanced in FETCH, so just move on.
                        IllegalOp  = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end

            S_EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 3'b010;
                state_next = S_WB_ALU;
            end

            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (OP)
                    OP_ANDI: ALUOp = 3'b100;
                    OP_ORI:  ALUOp = 3'b011;
                    OP_LUI:  ALUOp = 3'b101;
                    default: ALUOp = 3'b000;
                endcase
                state_next = S_WB_ALU;
            end

            S_WB_ALU: begin
                RegWrite   = 1'b1;
                RegDst     = rd_sel ? 2'b01 : 2'b00;
                retire     = 1'b1;
                state_next = S_FETCH;
            end

            S_MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = (OP == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                mem.IorD    = 1'b1;
                mem.MemRead = 1'b1;
                if (mem.MemReady) begin
                    state_next = S_WB_MEM;
                end else if (timeout) begin
                    MemError   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    wait_hold = 1'b1;
                end
            end

            S_WB_MEM: begin
                RegWrite   = 1'b1;
                MemtoReg   = 2'b01;
                retire     = 1'b1;
                state_next = S_FETCH;
            end

            S_MEM_WR: begin
                mem.IorD     = 1'b1;
                mem.MemWrite = 1'b1;
                if (mem.MemReady) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (timeout) begin
                    MemError   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    wait_hold = 1'b1;
                end
            end

            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 3'b001;
                PCSource   = 2'b01;
                PCWrite    = (OP == OP_BEQ) ? Zero : ~Zero;
                retire     = 1'b1;
                state_next = S_FETCH;
            end

            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                if (OP == OP_JAL) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                end
                retire     = 1'b1;
                state_next = S_FETCH;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
